// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point add/subtract.
//   Stage 1: effective-sign fixup, compare/swap, exponent difference, alignment
//            of the smaller significand with sticky collection; specials decoded.
//   Stage 2: significand add (with carry renormalise) or subtract.
//   Stage 3: leading-zero normalise, rounding, overflow/underflow, flags.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; op=0 -> a+b, op=1 -> a-b
//   a, b                  packed {sign, exp, mantis} operands
//   out_valid/out_ready   result handshake
//   result                packed result; zero/overflow/inexact status flags
// Build option: FP_ADDSUB_ROUND_NEAREST_EN selects round-to-nearest-even;
//   when undefined the result is truncated (round toward zero).

`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fp_addsub_pipe #(
  parameter int unsigned  EXP_SIZE    = `EXP_SIZE,
  parameter int unsigned  MANTIS_SIZE = `MANTIS_SIZE,
  localparam int unsigned W           = 1 + EXP_SIZE + MANTIS_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow,
  output logic         inexact
);

  localparam int unsigned E  = EXP_SIZE;
  localparam int unsigned M  = MANTIS_SIZE;
  localparam int unsigned SW = M + 4;            // {hidden, mantis, G, R, S}
  localparam int unsigned XW = E + 2;            // exponent with carry and sign guard
  localparam int unsigned LW = $clog2(SW) + 1;
  localparam logic [XW-1:0] EXP_MAX = {2'b00, {E{1'b1}}};

  // Flow control: a stage loads when empty or when its successor loads.
  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  assign ld3       = ~v3 | out_ready;
  assign ld2       = ~v2 | ld3;
  assign ld1       = ~v1 | ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  // Stage 1 combinational: decode, swap, align.
  logic          b_sign, a_zero, b_zero, a_inf, b_inf, swap, s_zero, s_lost;
  logic          l_sign;
  logic [W-2:0]  a_mag, b_mag;
  logic [E-1:0]  l_exp, s_exp, d;
  logic [M-1:0]  l_man, s_man;
  logic [SW-1:0] s_full, s_shift, s_al;
  logic          sp_en, sp_zero;
  logic [W-1:0]  sp_word;

  always_comb begin
    b_sign  = b[W-1] ^ op;
    a_zero  = a[W-2:M] == '0;
    b_zero  = b[W-2:M] == '0;
    a_inf   = &a[W-2:M];
    b_inf   = &b[W-2:M];
    a_mag   = a_zero ? '0 : a[W-2:0];
    b_mag   = b_zero ? '0 : b[W-2:0];
    swap    = b_mag > a_mag;
    l_sign  = swap ? b_sign    : a[W-1];
    l_exp   = swap ? b[W-2:M]  : a[W-2:M];
    l_man   = swap ? b[M-1:0]  : a[M-1:0];
    s_exp   = swap ? a[W-2:M]  : b[W-2:M];
    s_man   = swap ? a[M-1:0]  : b[M-1:0];
    s_zero  = swap ? a_zero    : b_zero;
    d       = l_exp - s_exp;
    s_full  = {1'b1, s_man, 3'b000};
    s_shift = s_full >> d;
    s_lost  = |(s_full ^ (s_shift << d));
    // Bits shifted out are jammed into the sticky position.
    if (s_zero)                  s_al = '0;
    else if (32'(d) > SW - 1)    s_al = SW'(1);
    else                         s_al = {s_shift[SW-1:1], s_shift[0] | s_lost};

    sp_en   = 1'b0;
    sp_zero = 1'b0;
    sp_word = '0;
    if (a_inf || b_inf) begin
      sp_en = 1'b1;
      if (a_inf && b_inf) sp_word = {a[W-1] & b_sign, {E{1'b1}}, {M{1'b0}}};
      else if (a_inf)     sp_word = {a[W-1],          {E{1'b1}}, {M{1'b0}}};
      else                sp_word = {b_sign,          {E{1'b1}}, {M{1'b0}}};
    end else if (a_zero && b_zero) begin
      sp_en   = 1'b1;
      sp_zero = 1'b1;
      sp_word = {a[W-1] & b_sign, {(W-1){1'b0}}};
    end
  end

  logic          s1_sign, s1_sub, s1_sp_en, s1_sp_zero;
  logic [E-1:0]  s1_exp;
  logic [SW-1:0] s1_sig_l, s1_sig_s;
  logic [W-1:0]  s1_sp_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_sp_en <= 1'b0; s1_sp_zero <= 1'b0;
      s1_exp <= '0; s1_sig_l <= '0; s1_sig_s <= '0; s1_sp_word <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign    <= l_sign;
        s1_sub     <= a[W-1] ^ b_sign;
        s1_exp     <= l_exp;
        s1_sig_l   <= {1'b1, l_man, 3'b000};
        s1_sig_s   <= s_al;
        s1_sp_en   <= sp_en;
        s1_sp_zero <= sp_zero;
        s1_sp_word <= sp_word;
      end
    end
  end

  // Stage 2 combinational: magnitude add or subtract (L >= S so never negative).
  logic [SW:0]   sum;
  logic [SW-1:0] sig2;
  logic [XW-1:0] exp2;

  always_comb begin
    sum  = {1'b0, s1_sig_l} + {1'b0, s1_sig_s};
    sig2 = sum[SW-1:0];
    exp2 = XW'(s1_exp);
    if (s1_sub) begin
      sig2 = s1_sig_l - s1_sig_s;
    end else if (sum[SW]) begin
      sig2 = {sum[SW:2], sum[1] | sum[0]};
      exp2 = XW'(s1_exp) + XW'(1);
    end
  end

  logic          s2_sign, s2_sp_en, s2_sp_zero;
  logic [XW-1:0] s2_exp;
  logic [SW-1:0] s2_sig;
  logic [W-1:0]  s2_sp_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; s2_sign <= 1'b0; s2_sp_en <= 1'b0; s2_sp_zero <= 1'b0;
      s2_exp <= '0; s2_sig <= '0; s2_sp_word <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign    <= s1_sign;
        s2_exp     <= exp2;
        s2_sig     <= sig2;
        s2_sp_en   <= s1_sp_en;
        s2_sp_zero <= s1_sp_zero;
        s2_sp_word <= s1_sp_word;
      end
    end
  end

  // Stage 3 combinational: normalise, round, classify.
  logic [LW-1:0] lz;
  logic [SW-1:0] norm;
  logic [XW-1:0] exp_n, exp_f;
  logic [M-1:0]  man;
  logic [2:0]    grs;
  logic          inc;
  logic [M+1:0]  rnd;
  logic [W-1:0]  res3;
  logic          zero3, ovf3, inx3;
  logic          unused_bits;

  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (s2_sig[i]) lz = LW'(SW - 1 - i);
    end
    norm  = s2_sig << lz;
    exp_n = s2_exp - XW'(lz);
    man   = norm[SW-2:3];
    grs   = norm[2:0];
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    inc   = grs[2] & ((|grs[1:0]) | man[0]);
`else
    inc   = 1'b0;
`endif
    rnd   = {2'b01, man} + (M+2)'(inc);
    // Rounding carry makes the significand 10.00..0: mantissa bits become zero.
    exp_f = exp_n + XW'(rnd[M+1]);

    res3  = {s2_sign, exp_f[E-1:0], rnd[M-1:0]};
    zero3 = 1'b0;
    ovf3  = 1'b0;
    inx3  = |grs;
    if (s2_sp_en) begin
      res3  = s2_sp_word;
      zero3 = s2_sp_zero;
      inx3  = 1'b0;
    end else if (s2_sig == '0) begin
      res3  = '0;
      zero3 = 1'b1;
      inx3  = 1'b0;
    end else if (exp_n[XW-1] || exp_n == '0) begin
      res3  = {s2_sign, {(W-1){1'b0}}};
      zero3 = 1'b1;
      inx3  = 1'b1;
    end else if (exp_f >= EXP_MAX) begin
      res3  = {s2_sign, {E{1'b1}}, {M{1'b0}}};
      ovf3  = 1'b1;
      inx3  = 1'b1;
    end
    unused_bits = norm[SW-1] ^ rnd[M];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; result <= '0; zero <= 1'b0; overflow <= 1'b0; inexact <= 1'b0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        result   <= res3;
        zero     <= zero3;
        overflow <= ovf3;
        inexact  <= inx3;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed testbench for fp_addsub_pipe (EXP_SIZE=8, MANTIS_SIZE=23).
module tb_fp_addsub_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, op, out_valid, out_ready;
  logic         zero, overflow, inexact;
  logic [W-1:0] a, b, result;

  int checks = 0;
  int errors = 0;

  fp_addsub_pipe #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;   // {zero, overflow, inexact}
  } vec_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [2:0]  flg;
    logic [31:0] res;
  } exp_t;

  vec_t  vecs [16];
  exp_t  exp_q [$];
  exp_t  cur_exp;
  exp_t  e;
  int    n_acc = 0;
  int    n_out = 0;
  logic        hold_pend = 1'b0;
  logic [34:0] hold_val;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Scoreboard: record accepted ops, compare emerging results, watch stalled outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) check("hold_stable", 64'({zero, overflow, inexact, result}), 64'(hold_val));
      hold_pend = out_valid & ~out_ready;
      hold_val  = {zero, overflow, inexact, result};
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_result", e.idx), 64'(result), 64'(e.res));
          check($sformatf("v%0d_flags", e.idx), 64'({zero, overflow, inexact}), 64'(e.flg));
        end
      end
    end else begin
      hold_pend = 1'b0;
      exp_q.delete();
    end
  end

  task automatic send(input int i);
    int   n = 0;
    logic acc = 1'b0;
    a        = vecs[i].a;
    b        = vecs[i].b;
    op       = vecs[i].op;
    cur_exp  = '{idx: 8'(i), flg: vecs[i].flg, res: vecs[i].res};
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check($sformatf("v%0d_accept_timeout", i), 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  int acc_base;
  int out_base;

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b100};
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    vecs[2]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001};
    vecs[15] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
`else
    vecs[2]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b001};
    vecs[15] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 3'b001};
`endif
    vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
    vecs[4]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000};
    vecs[5]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};
    vecs[6]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 3'b100};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b100};
    vecs[8]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
    vecs[9]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7F800000, 3'b000};
    vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
    vecs[11] = '{32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 3'b000};
    vecs[12] = '{32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b101};
    vecs[13] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001};
    vecs[14] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    cur_exp = '0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", 64'({zero, overflow, inexact, result}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Latency: valid appears on the third edge counting the accepting one.
    send(0);
    @(negedge clk);
    check("lat_cycle1", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_cycle2", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("lat_cycle3", 64'(out_valid), 64'(1));
    drain();

    // All directed vectors back to back.
    for (int i = 1; i < 16; i++) send(i);
    drain();

    // Output stall with six queued ops.
    out_ready = 1'b0;
    acc_base  = n_acc;
    fork
      begin
        send(0); send(4); send(5); send(11); send(13); send(6);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_accepted", 64'(n_acc - acc_base), 64'(3));
        check("stall_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_all_out", 64'(n_acc - acc_base), 64'(6));

    // Reset with three ops in flight discards them.
    out_ready = 1'b0;
    send(1); send(2); send(3);
    #1;
    rst_n = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    out_base  = n_out;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(1));
    repeat (8) @(posedge clk);
    #1;
    check("flush_none_out", 64'(n_out - out_base), 64'(0));

    // Unit still works after the flush.
    send(4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
